// File: rtl/rename_stage_pkg.sv
// Shared opcode constants, rename-stage sizing and the renamed-instruction record
// used by the rename stage and its free list.
package rename_stage_pkg;

    localparam logic [6:0] rtype = 7'b0110011;
    localparam logic [6:0] itype = 7'b0010011;
    localparam logic [6:0] lw    = 7'b0000011;
    localparam logic [6:0] sw    = 7'b0100011;

    localparam int ARCH_REGS  = 32;
    localparam int PHYS_REGS  = 64;
    localparam int FREE_DEPTH = 32;
    localparam int AREG_W     = 5;
    localparam int PREG_W     = 6;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [PREG_W-1:0] p_rs1;
        logic [PREG_W-1:0] p_rs2;
        logic [PREG_W-1:0] p_rd;
        logic [PREG_W-1:0] p_old_rd;
        logic [31:0]       imm;
        logic [6:0]        funct7;
        logic [2:0]        funct3;
    } rename_out_t;

    // x0 is never renamed; stores and bubbles have no destination.
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [AREG_W-1:0] rd);
        return ((opcode == rtype) || (opcode == itype) || (opcode == lw)) && (rd != '0);
    endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical registers: up to two pops from the head and two
// pushes at the tail per cycle. Resets holding BASE .. BASE+DEPTH-1 in order.
module free_list
    import rename_stage_pkg::*;
#(
    parameter int DEPTH = FREE_DEPTH,
    parameter int BASE  = ARCH_REGS,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pop_cnt,
    input  logic [PREG_W-1:0] push1,
    input  logic [PREG_W-1:0] push2,
    output logic [PREG_W-1:0] head0,
    output logic [PREG_W-1:0] head1,
    output logic [CNT_W-1:0]  count
);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  tail2;
    logic [1:0]        push_n;
    logic [CNT_W-1:0]  count_next;

    always_comb begin
        push_n     = 2'(push1 != '0) + 2'(push2 != '0);
        head0      = mem[head];
        head1      = mem[head + PTR_W'(1)];
        // push2 lands directly at tail when push1 is empty
        tail2      = (push1 != '0) ? tail + PTR_W'(1) : tail;
        count_next = count - CNT_W'(pop_cnt) + CNT_W'(push_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(BASE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            if (push1 != '0) begin
                mem[tail] <= push1;
            end
            if (push2 != '0) begin
                mem[tail2] <= push2;
            end
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_n);
            count <= count_next;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(count) + int'(push_n) - int'(pop_cnt)) <= DEPTH);

endmodule

// File: rtl/rename_stage.sv
// Dual-issue rename: RAT lookup with intra-pair bypass, free-list allocation and
// registered outputs feeding the reservation station.
module rename_stage #(
    parameter int ARCH_REGS = rename_stage_pkg::ARCH_REGS,
    parameter int PHYS_REGS = rename_stage_pkg::PHYS_REGS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  in1_opcode,
    input  logic [4:0]  in1_rs1,
    input  logic [4:0]  in1_rs2,
    input  logic [4:0]  in1_rd,
    input  logic [31:0] in1_imm,
    input  logic [6:0]  in1_funct7,
    input  logic [2:0]  in1_funct3,
    input  logic [6:0]  in2_opcode,
    input  logic [4:0]  in2_rs1,
    input  logic [4:0]  in2_rs2,
    input  logic [4:0]  in2_rd,
    input  logic [31:0] in2_imm,
    input  logic [6:0]  in2_funct7,
    input  logic [2:0]  in2_funct3,
    input  logic [5:0]  free_reg1,
    input  logic [5:0]  free_reg2,
    output logic        stall,
    output logic [6:0]  instr1_opcode,
    output logic [5:0]  instr1_p_rs1,
    output logic [5:0]  instr1_p_rs2,
    output logic [5:0]  instr1_p_rd,
    output logic [5:0]  instr1_p_old_rd,
    output logic [31:0] instr1_imm,
    output logic [6:0]  instr1_funct7,
    output logic [2:0]  instr1_funct3,
    output logic [6:0]  instr2_opcode,
    output logic [5:0]  instr2_p_rs1,
    output logic [5:0]  instr2_p_rs2,
    output logic [5:0]  instr2_p_rd,
    output logic [5:0]  instr2_p_old_rd,
    output logic [31:0] instr2_imm,
    output logic [6:0]  instr2_funct7,
    output logic [2:0]  instr2_funct3
);

    import rename_stage_pkg::*;

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_CNT_W = $clog2(FL_DEPTH) + 1;

    logic [PREG_W-1:0]   rat [ARCH_REGS];
    logic                wr1;
    logic                wr2;
    logic                same_rd;
    logic [1:0]          need;
    logic [1:0]          pop_cnt;
    logic [PREG_W-1:0]   head0;
    logic [PREG_W-1:0]   head1;
    logic [PREG_W-1:0]   p_rd1;
    logic [PREG_W-1:0]   p_rd2;
    logic [FL_CNT_W-1:0] count;
    rename_out_t         nxt1;
    rename_out_t         nxt2;
    rename_out_t         out1_q;
    rename_out_t         out2_q;

    always_comb begin
        wr1     = writes_rd(in1_opcode, in1_rd);
        wr2     = writes_rd(in2_opcode, in2_rd);
        same_rd = wr1 && (in2_rd == in1_rd);
        need    = 2'(wr1) + 2'(wr2);
        stall   = FL_CNT_W'(need) > count;
        pop_cnt = stall ? 2'd0 : need;
        p_rd1   = wr1 ? head0 : '0;
        p_rd2   = '0;
        if (wr2) begin
            p_rd2 = wr1 ? head1 : head0;
        end
    end

    always_comb begin
        nxt1 = '0;
        nxt2 = '0;
        if (!stall && (in1_opcode != '0)) begin
            nxt1.opcode   = in1_opcode;
            nxt1.p_rs1    = rat[in1_rs1];
            nxt1.p_rs2    = rat[in1_rs2];
            nxt1.p_rd     = p_rd1;
            nxt1.p_old_rd = wr1 ? rat[in1_rd] : '0;
            nxt1.imm      = in1_imm;
            nxt1.funct7   = in1_funct7;
            nxt1.funct3   = in1_funct3;
        end
        // Instruction 2 sees instruction 1's fresh mapping, not the stale RAT entry.
        if (!stall && (in2_opcode != '0)) begin
            nxt2.opcode   = in2_opcode;
            nxt2.p_rs1    = (wr1 && (in2_rs1 == in1_rd)) ? p_rd1 : rat[in2_rs1];
            nxt2.p_rs2    = (wr1 && (in2_rs2 == in1_rd)) ? p_rd1 : rat[in2_rs2];
            nxt2.p_rd     = p_rd2;
            nxt2.p_old_rd = '0;
            if (wr2) begin
                nxt2.p_old_rd = same_rd ? p_rd1 : rat[in2_rd];
            end
            nxt2.imm      = in2_imm;
            nxt2.funct7   = in2_funct7;
            nxt2.funct3   = in2_funct3;
        end
    end

    // Later nonblocking write wins, so instruction 2 owns a shared rd.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (!stall) begin
            if (wr1) begin
                rat[in1_rd] <= p_rd1;
            end
            if (wr2) begin
                rat[in2_rd] <= p_rd2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            out1_q <= nxt1;
            out2_q <= nxt2;
        end
    end

    free_list #(
        .DEPTH (FL_DEPTH),
        .BASE  (ARCH_REGS)
    ) u_free_list (
        .clk     (clk),
        .rst     (reset),
        .pop_cnt (pop_cnt),
        .push1   (free_reg1),
        .push2   (free_reg2),
        .head0   (head0),
        .head1   (head1),
        .count   (count)
    );

    assign instr1_opcode   = out1_q.opcode;
    assign instr1_p_rs1    = out1_q.p_rs1;
    assign instr1_p_rs2    = out1_q.p_rs2;
    assign instr1_p_rd     = out1_q.p_rd;
    assign instr1_p_old_rd = out1_q.p_old_rd;
    assign instr1_imm      = out1_q.imm;
    assign instr1_funct7   = out1_q.funct7;
    assign instr1_funct3   = out1_q.funct3;
    assign instr2_opcode   = out2_q.opcode;
    assign instr2_p_rs1    = out2_q.p_rs1;
    assign instr2_p_rs2    = out2_q.p_rs2;
    assign instr2_p_rd     = out2_q.p_rd;
    assign instr2_p_old_rd = out2_q.p_old_rd;
    assign instr2_imm      = out2_q.imm;
    assign instr2_funct7   = out2_q.funct7;
    assign instr2_funct3   = out2_q.funct3;

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: a sequential RAT/free-list model predicts each
// cycle's stall and renamed pair; a negedge monitor compares against the DUT.
module tb_rename_stage;
    import rename_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  in1_opcode, in2_opcode, in1_funct7, in2_funct7;
    logic [4:0]  in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd;
    logic [31:0] in1_imm, in2_imm;
    logic [2:0]  in1_funct3, in2_funct3;
    logic [5:0]  free_reg1, free_reg2;
    logic        stall;
    logic [6:0]  instr1_opcode, instr2_opcode, instr1_funct7, instr2_funct7;
    logic [5:0]  instr1_p_rs1, instr1_p_rs2, instr1_p_rd, instr1_p_old_rd;
    logic [5:0]  instr2_p_rs1, instr2_p_rs2, instr2_p_rd, instr2_p_old_rd;
    logic [31:0] instr1_imm, instr2_imm;
    logic [2:0]  instr1_funct3, instr2_funct3;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk(clk), .reset(reset),
        .in1_opcode(in1_opcode), .in1_rs1(in1_rs1), .in1_rs2(in1_rs2), .in1_rd(in1_rd),
        .in1_imm(in1_imm), .in1_funct7(in1_funct7), .in1_funct3(in1_funct3),
        .in2_opcode(in2_opcode), .in2_rs1(in2_rs1), .in2_rs2(in2_rs2), .in2_rd(in2_rd),
        .in2_imm(in2_imm), .in2_funct7(in2_funct7), .in2_funct3(in2_funct3),
        .free_reg1(free_reg1), .free_reg2(free_reg2), .stall(stall),
        .instr1_opcode(instr1_opcode), .instr1_p_rs1(instr1_p_rs1), .instr1_p_rs2(instr1_p_rs2),
        .instr1_p_rd(instr1_p_rd), .instr1_p_old_rd(instr1_p_old_rd), .instr1_imm(instr1_imm),
        .instr1_funct7(instr1_funct7), .instr1_funct3(instr1_funct3),
        .instr2_opcode(instr2_opcode), .instr2_p_rs1(instr2_p_rs1), .instr2_p_rs2(instr2_p_rs2),
        .instr2_p_rd(instr2_p_rd), .instr2_p_old_rd(instr2_p_old_rd), .instr2_imm(instr2_imm),
        .instr2_funct7(instr2_funct7), .instr2_funct3(instr2_funct3)
    );

    typedef struct {
        int          due;
        rename_out_t o1;
        rename_out_t o2;
    } exp_t;

    typedef struct {
        int due;
        bit stall;
        int cnt;
    } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];
    int   rat_m[32];
    int   fl_q[$];
    int   retire_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) rat_m[i] = i;
        fl_q.delete();
        for (int p = 32; p < 64; p++) fl_q.push_back(p);
        retire_q.delete();
    endfunction

    function automatic bit writer(logic [6:0] op, logic [4:0] rd);
        return (op == rtype || op == itype || op == lw) && rd != 5'd0;
    endfunction

    // Renames one instruction against the model RAT and applies it immediately,
    // so the second instruction of a pair naturally sees the first's mapping.
    task automatic rename_one(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic [31:0] imm,
                              input logic [6:0] f7, input logic [2:0] f3,
                              output rename_out_t r);
        int p;
        r = '0;
        if (op != 7'd0) begin
            r.opcode = op;
            r.p_rs1  = 6'(rat_m[a]);
            r.p_rs2  = 6'(rat_m[b]);
            r.imm    = imm;
            r.funct7 = f7;
            r.funct3 = f3;
            if (writer(op, d)) begin
                p          = fl_q.pop_front();
                r.p_rd     = 6'(p);
                r.p_old_rd = 6'(rat_m[d]);
                retire_q.push_back(rat_m[d]);
                rat_m[d]   = p;
            end
        end
    endtask

    task automatic drive(input logic [6:0] o1, input logic [4:0] a1, input logic [4:0] b1,
                         input logic [4:0] d1, input logic [6:0] o2, input logic [4:0] a2,
                         input logic [4:0] b2, input logic [4:0] d2,
                         input logic [5:0] f1, input logic [5:0] f2);
        exp_t e;
        int   need;
        bit   st;
        in1_opcode = o1; in1_rs1 = a1; in1_rs2 = b1; in1_rd = d1;
        in2_opcode = o2; in2_rs1 = a2; in2_rs2 = b2; in2_rd = d2;
        in1_imm = $urandom; in1_funct7 = 7'($urandom); in1_funct3 = 3'($urandom);
        in2_imm = $urandom; in2_funct7 = 7'($urandom); in2_funct3 = 3'($urandom);
        free_reg1 = f1; free_reg2 = f2;
        need = int'(writer(o1, d1)) + int'(writer(o2, d2));
        st   = need > fl_q.size();
        st_q.push_back('{cyc, st, fl_q.size()});
        e.due = cyc + 1;
        e.o1  = '0;
        e.o2  = '0;
        if (!st) begin
            rename_one(o1, a1, b1, d1, in1_imm, in1_funct7, in1_funct3, e.o1);
            rename_one(o2, a2, b2, d2, in2_imm, in2_funct7, in2_funct3, e.o2);
        end
        if (f1 != 6'd0) fl_q.push_back(int'(f1));
        if (f2 != 6'd0) fl_q.push_back(int'(f2));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_slot1", 128'({instr1_opcode, instr1_p_rs1, instr1_p_rs2, instr1_p_rd,
              instr1_p_old_rd, instr1_imm, instr1_funct7, instr1_funct3}), 128'd0);
        check("reset_slot2", 128'({instr2_opcode, instr2_p_rs1, instr2_p_rs2, instr2_p_rd,
              instr2_p_old_rd, instr2_imm, instr2_funct7, instr2_funct3}), 128'd0);
        check("reset_stall", 128'(stall), 128'd0);
        exp_q.delete();
        st_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_cycle();
        logic [6:0] ops [5];
        logic [5:0] f1, f2;
        int         nf;
        ops[0] = 7'd0; ops[1] = rtype; ops[2] = itype; ops[3] = lw; ops[4] = sw;
        nf = $urandom_range(0, 2);
        f1 = 6'd0;
        f2 = 6'd0;
        if (nf >= 1 && retire_q.size() > 0) f1 = 6'(retire_q.pop_front());
        if (nf >= 2 && retire_q.size() > 0) f2 = 6'(retire_q.pop_front());
        drive(ops[$urandom_range(0, 4)], 5'($urandom), 5'($urandom), 5'($urandom),
              ops[$urandom_range(0, 4)], 5'($urandom), 5'($urandom), 5'($urandom), f1, f2);
    endtask

    initial begin : monitor
        st_t  s;
        exp_t e;
        forever begin
            @(negedge clk);
            while (st_q.size() > 0 && st_q[0].due <= cyc) begin
                s = st_q.pop_front();
                check("stall", 128'(stall), 128'(s.stall));
                check("free_count", 128'(dut.u_free_list.count), 128'(s.cnt));
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("slot1", 128'({instr1_opcode, instr1_p_rs1, instr1_p_rs2, instr1_p_rd,
                      instr1_p_old_rd, instr1_imm, instr1_funct7, instr1_funct3}), 128'(e.o1));
                check("slot2", 128'({instr2_opcode, instr2_p_rs1, instr2_p_rs2, instr2_p_rd,
                      instr2_p_old_rd, instr2_imm, instr2_funct7, instr2_funct3}), 128'(e.o2));
            end
        end
    end

    initial begin : stimulus
        in1_opcode = '0; in1_rs1 = '0; in1_rs2 = '0; in1_rd = '0;
        in2_opcode = '0; in2_rs1 = '0; in2_rs2 = '0; in2_rd = '0;
        in1_imm = '0; in1_funct7 = '0; in1_funct3 = '0;
        in2_imm = '0; in2_funct7 = '0; in2_funct3 = '0;
        free_reg1 = '0; free_reg2 = '0;
        #2;
        do_reset();

        // add x1,x2,x3 ; addi x4,x1,5
        drive(rtype, 5'd2, 5'd3, 5'd1, itype, 5'd1, 5'd0, 5'd4, 6'd0, 6'd0);
        check("pair_p_rd1", 128'(instr1_p_rd), 128'd32);
        check("pair_p_rs1_bypass", 128'(instr2_p_rs1), 128'd32);
        check("pair_count", 128'(dut.u_free_list.count), 128'd30);

        do_reset();
        drive(rtype, 5'd6, 5'd7, 5'd5, rtype, 5'd8, 5'd9, 5'd5, 6'd0, 6'd0);
        check("collide_old2", 128'(instr2_p_old_rd), 128'd32);
        check("collide_rat5", 128'(dut.rat[5]), 128'd33);

        // sw x7,0(x6) ; addi x0,x1,1
        drive(sw, 5'd6, 5'd7, 5'd3, itype, 5'd1, 5'd0, 5'd0, 6'd0, 6'd0);
        check("sw_p_rs2", 128'(instr1_p_rs2), 128'd7);
        check("sw_count", 128'(dut.u_free_list.count), 128'd30);

        do_reset();
        for (int k = 0; k < 16; k++)
            drive(rtype, 5'($urandom), 5'($urandom), 5'd1, rtype, 5'($urandom), 5'($urandom),
                  5'd4, 6'd0, 6'd0);
        check("exhaust_count", 128'(dut.u_free_list.count), 128'd0);
        in1_opcode = rtype; in1_rd = 5'd1; in2_opcode = rtype; in2_rd = 5'd4;
        #1;
        check("exhaust_stall", 128'(stall), 128'd1);
        drive(rtype, 5'd2, 5'd3, 5'd1, rtype, 5'd1, 5'd2, 5'd4, 6'd1, 6'd4);
        drive(rtype, 5'd2, 5'd3, 5'd1, rtype, 5'd1, 5'd2, 5'd4, 6'd0, 6'd0);
        check("refill_p_rd1", 128'(instr1_p_rd), 128'd1);
        check("refill_p_rd2", 128'(instr2_p_rd), 128'd4);

        do_reset();
        for (int k = 0; k < 150; k++) rand_cycle();
        do_reset();
        drive(rtype, 5'd1, 5'd2, 5'd3, 7'd0, 5'd0, 5'd0, 5'd0, 6'd0, 6'd0);
        check("post_reset_p_rd", 128'(instr1_p_rd), 128'd32);
        for (int k = 0; k < 250; k++) rand_cycle();

        drive(7'd0, 5'd0, 5'd0, 5'd0, 7'd0, 5'd0, 5'd0, 5'd0, 6'd0, 6'd0);
        for (int i = 0; i < 5 && (exp_q.size() + st_q.size()) > 0; i++) @(negedge clk);
        #1;
        check("drain_empty", 128'(exp_q.size() + st_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
